// File: rtl/window_accumulator.sv
// ----------------------------------------------------------------------------
// window_accumulator
//
// Sums exactly WINDOW_P accepted input beats into an ACC_WIDTH_P-bit register.
// Presents each window total with a per-window overflow flag, then restarts
// from zero. Typical use: decimation or averaging front-end between a sample
// producer and a downstream consumer.
//
// Handshakes (both sides): a beat moves when valid and ready are both high on
// a rising clk_i edge. Once raised, valid_o and its payload (sum_o, ovf_o)
// stay stable until ready_i is seen high. ready_o depends only on internal
// state, never on valid_i.
//
// Parameters:
//   WIDTH_P      input sample width (unsigned)
//   ACC_WIDTH_P  accumulator/result width, >= WIDTH_P
//   WINDOW_P     accepted beats per window, >= 1
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   clear_i  synchronous flush of partial window and pending result
//   data_i   input sample
//   valid_i  data_i valid
//   ready_o  block can accept a beat (high in ACCUM state)
//   sum_o    window total
//   ovf_o    carry-out seen during this window, qualified by valid_o
//   valid_o  sum_o/ovf_o valid (high in HOLD state)
//   ready_i  downstream accepts result
//   state_o  debug view of the FSM state (0 = ACCUM, 1 = HOLD)
//
// Build option:
//   WINDOW_ACCUMULATOR_SAT_EN  when defined, the accumulator saturates at
//   all ones on carry-out instead of wrapping. ovf_o behaves the same.
// ----------------------------------------------------------------------------
module window_accumulator #(
    parameter int WIDTH_P     = 8,
    parameter int ACC_WIDTH_P = 16,
    parameter int WINDOW_P    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [WIDTH_P-1:0]     data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [ACC_WIDTH_P-1:0] sum_o,
    output logic                   ovf_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   state_o
);

    localparam int CNT_W = (WINDOW_P > 1) ? $clog2(WINDOW_P) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_P - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH_P-1:0] acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;
    logic [ACC_WIDTH_P-1:0] sum_q;
    logic                   ovf_out_q;

    logic                   accept;
    logic                   last_beat;
    logic [ACC_WIDTH_P:0]   add_full;
    logic                   carry;
    logic [ACC_WIDTH_P-1:0] add_res;

    // One extra bit on the adder captures the carry-out of the accumulator.
    assign add_full  = {1'b0, acc_q} + {{(ACC_WIDTH_P + 1 - WIDTH_P){1'b0}}, data_i};
    assign carry     = add_full[ACC_WIDTH_P];
    assign last_beat = (cnt_q == LAST_CNT);

`ifdef WINDOW_ACCUMULATOR_SAT_EN
    // Once at all ones, any further non-zero add carries again, so the
    // value pins at the ceiling for the rest of the window.
    assign add_res = carry ? {ACC_WIDTH_P{1'b1}} : add_full[ACC_WIDTH_P-1:0];
`else
    assign add_res = add_full[ACC_WIDTH_P-1:0];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ready_o = (state_q == ACCUM);
        valid_o = (state_q == HOLD);
        accept  = valid_i && (state_q == ACCUM);

        unique case (state_q)
            ACCUM: if (accept && last_beat) state_d = HOLD;
            HOLD:  if (ready_i)             state_d = ACCUM;
            default: state_d = ACCUM;
        endcase

        // clear_i overrides everything, including a pending result.
        if (clear_i) state_d = ACCUM;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            ovf_out_q <= 1'b0;
        end else if (clear_i) begin
            // sum_q/ovf_out_q are left alone; they are don't-care while
            // valid_o is low.
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                sum_q     <= add_res;
                ovf_out_q <= ovf_q | carry;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else begin
                acc_q <= add_res;
                cnt_q <= cnt_q + CNT_W'(1);
                ovf_q <= ovf_q | carry;
            end
        end
    end

    assign sum_o   = sum_q;
    assign ovf_o   = ovf_out_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_window_accumulator.sv
// ----------------------------------------------------------------------------
// tb_window_accumulator
//
// Bench for window_accumulator with WIDTH_P=8, ACC_WIDTH_P=9, WINDOW_P=4.
// Table-driven directed vectors, hand-written multi-cycle sequences
// (backpressure, clear, asynchronous reset), then randomized traffic scored
// against a window-sum reference model.
// ----------------------------------------------------------------------------
module tb_window_accumulator;

    localparam int WIDTH = 8;
    localparam int ACC   = 9;
    localparam int WIN   = 4;

`ifdef WINDOW_ACCUMULATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_ni;
    logic             clear_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic [ACC-1:0]   sum_o;
    logic             ovf_o;
    logic             valid_o;
    logic             ready_i;
    logic             state_o;

    window_accumulator #(
        .WIDTH_P    (WIDTH),
        .ACC_WIDTH_P(ACC),
        .WINDOW_P   (WIN)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .sum_o  (sum_o),
        .ovf_o  (ovf_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .state_o(state_o)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, then settle 1 time unit so outputs
    // are sampled away from the edge.
    task automatic apply(input logic v, input logic [WIDTH-1:0] d,
                         input logic r, input logic c);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clear_i = c;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model ----------------
    // A window result is simply the plain integer total of its beats,
    // reduced to ACC bits either by wrapping or by clamping.
    function automatic logic [ACC:0] model_result(input int total);
        logic           ovf;
        logic [ACC-1:0] s;
        ovf = (total >= (1 << ACC));
        if (ovf && SAT) s = ACC'((1 << ACC) - 1);
        else            s = ACC'(total % (1 << ACC));
        return {ovf, s};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             r;
        logic             c;
        logic             ev;   // expected valid_o after the edge
        logic [ACC-1:0]   es;   // expected sum_o (checked when ev)
        logic             eo;   // expected ovf_o (checked when ev)
        logic             er;   // expected ready_o after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic v, input int d, input logic r, input logic c,
                           input logic ev, input int es, input logic eo, input logic er);
        vec_t x;
        x.v  = v;
        x.d  = WIDTH'(d);
        x.r  = r;
        x.c  = c;
        x.ev = ev;
        x.es = ACC'(es);
        x.eo = eo;
        x.er = er;
        tbl.push_back(x);
    endtask

    // ---------------- scoreboard for random phase ----------------
    logic [ACC:0] exp_q[$];
    int           win_q[$];
    bit           m_hold;

    logic [ACC:0] res;
    int           total;
    logic         vi, ri, ci;
    logic [WIDTH-1:0] di;

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_valid", int'(valid_o), 0);
        check("rst_sum",   int'(sum_o),   0);
        check("rst_ovf",   int'(ovf_o),   0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        check("rst_ready", int'(ready_o), 1);

        // ---------------- directed table ----------------
        // Basic window 1,2,3,4
        add_vec(1, 1, 1, 0, 0, 0, 0, 1);
        add_vec(1, 2, 1, 0, 0, 0, 0, 1);
        add_vec(1, 3, 1, 0, 0, 0, 0, 1);
        add_vec(1, 4, 1, 0, 1, 10, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 1);
        // Overflow 255 x4, then a beat offered during HOLD must be ignored
        for (int k = 0; k < 3; k++) add_vec(1, 255, 1, 0, 0, 0, 0, 1);
        add_vec(1, 255, 1, 0, 1, SAT ? 511 : 508, 1, 0);
        add_vec(1, 77, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) add_vec(1, 1, 1, 0, 0, 0, 0, 1);
        add_vec(1, 1, 1, 0, 1, 4, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 1);
        // Zeros with 2 idle cycles between beats
        for (int k = 0; k < 3; k++) begin
            add_vec(1, 0, 1, 0, 0, 0, 0, 1);
            add_vec(0, 0, 1, 0, 0, 0, 0, 1);
            add_vec(0, 0, 1, 0, 0, 0, 0, 1);
        end
        add_vec(1, 7, 1, 0, 1, 7, 0, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
            check($sformatf("tbl%0d_valid", i), int'(valid_o), int'(tbl[i].ev));
            check($sformatf("tbl%0d_ready", i), int'(ready_o), int'(tbl[i].er));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_sum", i), int'(sum_o), int'(tbl[i].es));
                check($sformatf("tbl%0d_ovf", i), int'(ovf_o), int'(tbl[i].eo));
            end
        end

        // ---------------- backpressure ----------------
        for (int k = 0; k < 4; k++) begin
            apply(1, 5, 0, 0);
            check("bp_valid_fill", int'(valid_o), (k == 3) ? 1 : 0);
        end
        for (int k = 0; k < 6; k++) begin
            apply(1, 99, 0, 0);
            check("bp_hold_valid", int'(valid_o), 1);
            check("bp_hold_sum",   int'(sum_o),   20);
            check("bp_hold_ovf",   int'(ovf_o),   0);
            check("bp_hold_ready", int'(ready_o), 0);
        end
        apply(0, 0, 1, 0);
        check("bp_ack_valid", int'(valid_o), 0);
        check("bp_ack_ready", int'(ready_o), 1);
        for (int k = 1; k <= 4; k++) apply(1, WIDTH'(k), 1, 0);
        check("bp_restart_valid", int'(valid_o), 1);
        check("bp_restart_sum",   int'(sum_o),   10);
        apply(0, 0, 1, 0);

        // ---------------- clear mid-window ----------------
        apply(1, 9, 1, 0);
        apply(1, 9, 1, 0);
        apply(1, 50, 1, 1);
        check("clr_valid", int'(valid_o), 0);
        check("clr_ready", int'(ready_o), 1);
        for (int k = 0; k < 4; k++) apply(1, 1, 1, 0);
        check("clr_win_valid", int'(valid_o), 1);
        check("clr_win_sum",   int'(sum_o),   4);
        apply(0, 0, 1, 0);

        // ---------------- clear during HOLD ----------------
        for (int k = 0; k < 4; k++) apply(1, 3, 0, 0);
        check("clrh_pre_valid", int'(valid_o), 1);
        check("clrh_pre_sum",   int'(sum_o),   12);
        apply(0, 0, 0, 1);
        check("clrh_valid", int'(valid_o), 0);
        check("clrh_ready", int'(ready_o), 1);
        apply(0, 0, 1, 0);
        check("clrh_idle_valid", int'(valid_o), 0);
        for (int k = 0; k < 4; k++) apply(1, 2, 1, 0);
        check("clrh_next_sum", int'(sum_o), 8);
        apply(0, 0, 1, 0);

        // ---------------- async reset mid-HOLD ----------------
        for (int k = 0; k < 4; k++) apply(1, 6, 0, 0);
        check("arst_pre_valid", int'(valid_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", int'(valid_o), 0);
        check("arst_sum",   int'(sum_o),   0);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 0);
        rst_ni = 1'b1;
        #1;
        check("arst_ready", int'(ready_o), 1);
        for (int k = 0; k < 4; k++) apply(1, 2, 1, 0);
        check("arst_win_valid", int'(valid_o), 1);
        check("arst_win_sum",   int'(sum_o),   8);
        check("arst_win_ovf",   int'(ovf_o),   0);
        apply(0, 0, 1, 0);

        // ---------------- randomized traffic ----------------
        m_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            vi = ($urandom_range(0, 3) != 0);
            di = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(200, 255))
                                             : WIDTH'($urandom_range(0, 255));
            ri = ($urandom_range(0, 2) != 0);
            ci = ($urandom_range(0, 40) == 0);

            if (ci) begin
                win_q.delete();
                if (m_hold) exp_q.delete(0);
                m_hold = 1'b0;
            end else if (!m_hold) begin
                if (vi) begin
                    win_q.push_back(int'(di));
                    if (win_q.size() == WIN) begin
                        total = 0;
                        foreach (win_q[k]) total += win_q[k];
                        exp_q.push_back(model_result(total));
                        win_q.delete();
                        m_hold = 1'b1;
                    end
                end
            end else if (ri) begin
                exp_q.delete(0);
                m_hold = 1'b0;
            end

            apply(vi, di, ri, ci);
            check("rnd_valid", int'(valid_o), int'(m_hold));
            check("rnd_ready", int'(ready_o), int'(!m_hold));
            if (m_hold && exp_q.size() > 0) begin
                res = exp_q[0];
                check("rnd_sum", int'(sum_o), int'(res[ACC-1:0]));
                check("rnd_ovf", int'(ovf_o), int'(res[ACC]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
Fixed-length windowed accumulator with valid/ready handshakes on both sides, generalising the single-register running accumulator. Sums exactly WINDOW_P accepted input beats into an ACC_WIDTH_P-bit register. Presents each window total with a per-window overflow flag, then restarts from zero. Sits between a sample stream producer and a downstream consumer, e.g. decimation or averaging front-end.

Parameters:
WIDTH_P, 8, input sample width (unsigned).
ACC_WIDTH_P, 16, accumulator/result width; must be >= WIDTH_P.
WINDOW_P, 16, accepted beats per window; must be >= 1. Counter width = $clog2(WINDOW_P), minimum 1 bit (localparam).

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_ni  in  1  reset, asynchronous assert, active-low.
clear_i  in  1  synchronous flush of partial window and pending result.
data_i  in  WIDTH_P  input sample.
valid_i  in  1  data_i valid.
ready_o  out  1  block can accept a beat.
sum_o  out  ACC_WIDTH_P  window total.
ovf_o  out  1  overflow occurred in this window; qualified by valid_o.
valid_o  out  1  sum_o/ovf_o valid.
ready_i  in  1  downstream accepts result.

Behaviour:
- Reset (rst_ni low, async): state=ACCUM, acc=0, cnt=0, ovf accumulator=0, sum_o=0, ovf_o=0, valid_o=0. ready_o=1 once rst_ni deasserts.
- Beat accept: valid_i && ready_o. ready_o = (state==ACCUM). It is combinational from state only and never depends on valid_i.
- Every accepted beat counts toward the window, including data_i==0. Zero samples are not skipped.
- ACCUM state:
  - On accept with cnt < WINDOW_P-1: acc <= acc + zext(data_i); cnt++. Set the internal sticky ovf if the add carries out of ACC_WIDTH_P.
  - On accept with cnt == WINDOW_P-1: sum_o <= acc + zext(data_i). ovf_o <= sticky ovf | carry of this add. valid_o <= 1. acc, cnt and sticky ovf <= 0. Go to HOLD.
  - Latency: valid_o rises the cycle after the last beat of the window is accepted.
- HOLD state:
  - ready_o=0. valid_i is ignored and no beat is consumed.
  - sum_o and ovf_o stay stable while valid_o=1 and ready_i=0.
  - On ready_i=1: valid_o <= 0; go to ACCUM. ready_o is 1 on the following cycle.
- WINDOW_P=1: every accepted beat produces a result; ACCUM and HOLD alternate.
- Arithmetic: unsigned; default wraps modulo 2^ACC_WIDTH_P.
- clear_i (synchronous, highest priority after reset):
  - acc, cnt and sticky ovf <= 0; valid_o <= 0; state <= ACCUM.
  - A beat presented in the same cycle is dropped. A pending HOLD result is discarded.
  - sum_o keeps its last value; it is don't-care while valid_o=0.
- Reset mid-window or mid-HOLD: all state cleared immediately. A partial window or pending result is lost.

Optional Feature:
Macro WINDOW_ACCUMULATOR_SAT_EN.
- Defined: on carry-out, acc saturates to all ones (2^ACC_WIDTH_P-1) and stays there for the rest of the window. sum_o reports the saturated value.
- Not defined: wrap-around arithmetic.
- ovf_o is set identically in both builds.

Test Plan:
All tests use WIDTH_P=8, ACC_WIDTH_P=9, WINDOW_P=4.
1. Basic window: beats 1,2,3,4 back-to-back, ready_i=1 -> valid_o for 1 cycle, one cycle after beat 4; sum_o=10, ovf_o=0; ready_o=0 only in that HOLD cycle.
2. Overflow: beats 255×4 -> without SAT_EN sum_o=508 (1020 mod 512), ovf_o=1. With WINDOW_ACCUMULATOR_SAT_EN sum_o=511, ovf_o=1. The next window of 1,1,1,1 gives sum_o=4, ovf_o=0.
3. Backpressure: window 5,5,5,5 with ready_i=0 for 6 cycles -> sum_o=20 and valid_o=1 held stable. ready_o=0 and valid_i beats ignored throughout. After ready_i=1, the next window restarts at 0.
4. Zeros and gaps: beats 0,0,0,7 with 2 idle cycles between each -> exactly one result, sum_o=7.
5. Clear: accept 9,9, then clear_i with valid_i=1 data 50, then beats 1,1,1,1 -> sum_o=4. A separate case asserts clear_i during HOLD -> valid_o drops next cycle and the result is never acknowledged.
6. Async reset: drop rst_ni mid-HOLD between clock edges -> valid_o=0 immediately. After release, beats 2,2,2,2 -> sum_o=8.
